// File: rtl/scheduler_pragmatic_mb.sv
// Essential-bit weight scheduler: issues up to NUM_OFF lowest set-bit offsets per lane per beat.
// Define SCHED_PRAG_PRELOAD_EN to add a one-entry shadow register for back-to-back weight sets.
module scheduler_pragmatic_mb #(
    parameter int  DATA_WIDTH = 8,
    parameter int  VEC_LENGTH = 16,
    parameter int  NUM_OFF    = 2,
    localparam int MAG_W      = DATA_WIDTH - 1,
    localparam int OFF_W      = $clog2(MAG_W)
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]     in_weight,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [VEC_LENGTH-1:0][NUM_OFF*OFF_W-1:0]  out_offset,
    output logic [VEC_LENGTH-1:0][NUM_OFF-1:0]        out_val,
    output logic [VEC_LENGTH-1:0]                     out_sign,
    output logic                                      out_last,
    output logic [OFF_W:0]                            out_beat,
    output logic                                      busy
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_next;

    logic [VEC_LENGTH-1:0][MAG_W-1:0]      work_mag;
    logic [VEC_LENGTH-1:0][MAG_W-1:0]      mag_next;
    logic [VEC_LENGTH-1:0][MAG_W-1:0]      load_mag;
    logic [VEC_LENGTH-1:0]                 work_sign;
    logic [VEC_LENGTH-1:0]                 load_sign;
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] load_weight;
    logic [OFF_W:0]                        beat_cnt;
    logic                                  take_in;
    logic                                  beat_accept;
    logic                                  set_done;
    logic                                  load_work;

    assign take_in     = in_valid & in_ready;
    assign beat_accept = (state == RUN) & out_ready;
    assign set_done    = beat_accept & out_last;

`ifdef SCHED_PRAG_PRELOAD_EN
    logic                                  shadow_full;
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] shadow_weight;

    assign in_ready = ~shadow_full;

    // The shadow only catches a set while the work reg is still busy with the current one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_full   <= 1'b0;
            shadow_weight <= '0;
        end else if (take_in && (state == RUN) && !set_done) begin
            shadow_full   <= 1'b1;
            shadow_weight <= in_weight;
        end else if (set_done && shadow_full) begin
            shadow_full   <= 1'b0;
        end
    end
`else
    assign in_ready = (state == IDLE);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        load_work   = 1'b0;
        load_weight = in_weight;
        case (state)
            IDLE: begin
                if (take_in) begin
                    load_work  = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (set_done) begin
`ifdef SCHED_PRAG_PRELOAD_EN
                    if (shadow_full) begin
                        load_work   = 1'b1;
                        load_weight = shadow_weight;
                    end else if (take_in) begin
                        load_work   = 1'b1;
                    end else begin
                        state_next  = IDLE;
                    end
`else
                    state_next = IDLE;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_mag  = '0;
        load_sign = '0;
        for (int l = 0; l < VEC_LENGTH; l++) begin
            load_mag[l]  = load_weight[l][MAG_W-1:0];
            load_sign[l] = load_weight[l][DATA_WIDTH-1];
        end
    end

    // Scan each lane LSB-first; the rank of a set bit selects the slot it lands in.
    always_comb begin
        int rank;
        out_offset = '0;
        out_val    = '0;
        mag_next   = work_mag;
        rank       = 0;
        for (int l = 0; l < VEC_LENGTH; l++) begin
            rank = 0;
            for (int b = 0; b < MAG_W; b++) begin
                if (work_mag[l][b]) begin
                    for (int k = 0; k < NUM_OFF; k++) begin
                        if (rank == k) begin
                            out_offset[l][k*OFF_W +: OFF_W] = OFF_W'(b);
                            out_val[l][k]                   = 1'b1;
                            mag_next[l][b]                  = 1'b0;
                        end
                    end
                    rank = rank + 1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work_mag  <= '0;
            work_sign <= '0;
            beat_cnt  <= '0;
        end else if (load_work) begin
            work_mag  <= load_mag;
            work_sign <= load_sign;
            beat_cnt  <= '0;
        end else if (beat_accept) begin
            work_mag  <= mag_next;
            beat_cnt  <= set_done ? '0 : beat_cnt + (OFF_W+1)'(1);
        end
    end

    // An all-zero set still produces one (empty) final beat because mag_next is already zero.
    assign out_last  = (state == RUN) && (mag_next == '0);
    assign out_valid = (state == RUN);
    assign busy      = (state == RUN);
    assign out_sign  = work_sign;
    assign out_beat  = beat_cnt;

endmodule
